// File: rtl/seg_note_decoder.sv
// Recovers {TOM, NOTAS} from a 7-segment bus once a pattern has been stable for
// STABLE_CYCLES samples; flags unknown patterns and counts accepted notes.
module seg_note_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [6:0]       Segmentos,
  output logic             TOM,
  output logic [2:0]       NOTAS,
  output logic             Valido,
  output logic             Novo,
  output logic             Erro,
  output logic [CNT_W-1:0] Contador
);

  typedef enum logic [1:0] {APAGADO, ESPERA, TRAVADO, INVALIDO} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t           state_q, state_d;
  logic [6:0]       seg_q;
  logic [7:0]       run_q, run_d;
  logic             tom_q, tom_d;
  logic [2:0]       notas_q, notas_d;
  logic             novo_q, novo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       dec;
  logic             changed;

  // Returns {hit, TOM, NOTAS}; hit=0 for anything outside the table (00 included).
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h4E:   decode = 5'b1_0_000;
      7'h3D:   decode = 5'b1_0_001;
      7'h4F:   decode = 5'b1_0_010;
      7'h47:   decode = 5'b1_0_011;
      7'h5E:   decode = 5'b1_0_100;
      7'h77:   decode = 5'b1_0_101;
      7'h1F:   decode = 5'b1_0_110;
      7'h01:   decode = 5'b1_0_111;
      7'h7E:   decode = 5'b1_1_000;
      7'h30:   decode = 5'b1_1_001;
      7'h6D:   decode = 5'b1_1_010;
      7'h79:   decode = 5'b1_1_011;
      7'h33:   decode = 5'b1_1_100;
      7'h5B:   decode = 5'b1_1_101;
      7'h5F:   decode = 5'b1_1_110;
      7'h70:   decode = 5'b1_1_111;
      default: decode = 5'b0_0_000;
    endcase
  endfunction

  always_comb begin
    dec     = decode(Segmentos);
    changed = (Segmentos != seg_q);
    run_d   = changed ? 8'd1 : ((run_q >= STABLE) ? STABLE : run_q + 8'd1);
    state_d = state_q;
    tom_d   = tom_q;
    notas_d = notas_q;
    novo_d  = 1'b0;
    cnt_d   = cnt_q;
    if (Segmentos == 7'h00) begin
      state_d = APAGADO;
    end else if (!changed && (state_q == TRAVADO || state_q == INVALIDO)) begin
      state_d = state_q;
    end else if (run_d >= STABLE) begin
      // Acceptance edge: latch the note and pulse Novo exactly once per lock.
      if (dec[4]) begin
        state_d = TRAVADO;
        tom_d   = dec[3];
        notas_d = dec[2:0];
        novo_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        state_d = INVALIDO;
      end
    end else begin
      state_d = ESPERA;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= APAGADO;
      seg_q   <= 7'h00;
      run_q   <= 8'd0;
      tom_q   <= 1'b0;
      notas_q <= 3'd0;
      novo_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= Segmentos;
      run_q   <= run_d;
      tom_q   <= tom_d;
      notas_q <= notas_d;
      novo_q  <= novo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign TOM      = tom_q;
  assign NOTAS    = notas_q;
  assign Valido   = (state_q == TRAVADO);
  assign Erro     = (state_q == INVALIDO);
  assign Novo     = novo_q;
  assign Contador = cnt_q;

endmodule

// File: tb/tb_seg_note_decoder.sv
// Directed bench for seg_note_decoder: a history-based reference model queues the
// expected outputs per driven sample; they are popped and compared after each edge.
module tb_seg_note_decoder;

  localparam int S = 4;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [6:0] Segmentos = 7'h00;
  logic       TOM;
  logic [2:0] NOTAS;
  logic       Valido, Novo, Erro;
  logic [7:0] Contador;

  seg_note_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Segmentos(Segmentos),
    .TOM(TOM), .NOTAS(NOTAS), .Valido(Valido), .Novo(Novo),
    .Erro(Erro), .Contador(Contador)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       tom;
    logic [2:0] notas;
    logic       vld;
    logic       novo;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   novo_seen = 0;
  int   err_seen = 0;

  logic [6:0] codes [16] = '{7'h4E, 7'h3D, 7'h4F, 7'h47, 7'h5E, 7'h77, 7'h1F, 7'h01,
                             7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

  // Reference model state: unbounded run length of the current sample.
  logic [6:0] m_prev = 7'h00;
  int         m_run = 0;
  logic       m_tom = 1'b0;
  logic [2:0] m_notas = 3'd0;
  logic [7:0] m_cnt = 8'd0;

  function automatic int lookup(input logic [6:0] seg);
    int idx = -1;
    for (int i = 0; i < 16; i++) if (codes[i] == seg && seg != 7'h00) idx = i;
    return idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic rn, input logic [6:0] seg, output exp_t e);
    int  idx;
    logic held;
    e = '0;
    if (!rn) begin
      m_prev = 7'h00; m_run = 0; m_tom = 1'b0; m_notas = 3'd0; m_cnt = 8'd0;
    end else begin
      m_run  = (seg != m_prev) ? 1 : m_run + 1;
      m_prev = seg;
      idx    = lookup(seg);
      held   = (seg != 7'h00) && (m_run >= S);
      e.vld  = held && (idx >= 0);
      e.err  = held && (idx < 0);
      e.novo = (seg != 7'h00) && (idx >= 0) && (m_run == S);
      if (e.novo) begin
        {m_tom, m_notas} = idx[3:0];
        m_cnt = m_cnt + 8'd1;
      end
    end
    e.tom = m_tom; e.notas = m_notas; e.cnt = m_cnt;
  endtask

  task automatic step(input logic rn, input logic [6:0] seg);
    exp_t e;
    Reset_n = rn;
    Segmentos = seg;
    model(rn, seg, e);
    sbq.push_back(e);
    @(posedge Clock);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("TOM", 32'(TOM), 32'(e.tom));
      chk("NOTAS", 32'(NOTAS), 32'(e.notas));
      chk("Valido", 32'(Valido), 32'(e.vld));
      chk("Novo", 32'(Novo), 32'(e.novo));
      chk("Erro", 32'(Erro), 32'(e.err));
      chk("Contador", 32'(Contador), 32'(e.cnt));
    end
    if (Novo === 1'b1) novo_seen++;
    if (Erro === 1'b1) err_seen++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // T1: reset with 77 present, then acceptance after 4 edges
    step(1'b0, 7'h77);
    step(1'b0, 7'h77);
    chk("t1_rst_vld", 32'(Valido), 32'd0);
    chk("t1_rst_cnt", 32'(Contador), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 7'h77);
    chk("t1_pre_vld", 32'(Valido), 32'd0);
    step(1'b1, 7'h77);
    chk("t1_vld", 32'(Valido), 32'd1);
    chk("t1_note", 32'({TOM, NOTAS}), 32'h5);
    chk("t1_novo", 32'(Novo), 32'd1);
    chk("t1_cnt", 32'(Contador), 32'd1);
    step(1'b1, 7'h77);
    chk("t1_novo_off", 32'(Novo), 32'd0);

    // T2: sweep of all table codes
    novo_seen = 0; err_seen = 0;
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 6; k++) step(1'b1, codes[c]);
      chk($sformatf("t2_note_%0d", c), 32'({TOM, NOTAS}), 32'(c));
      chk($sformatf("t2_vld_%0d", c), 32'(Valido), 32'd1);
    end
    chk("t2_novo_pulses", 32'(novo_seen), 32'd16);
    chk("t2_err_seen", 32'(err_seen), 32'd0);
    chk("t2_cnt", 32'(Contador), 32'd17);

    // T3: short-lived 4E is never accepted, 5E is
    step(1'b1, 7'h4E);
    step(1'b1, 7'h4E);
    chk("t3_hold_notas", 32'(NOTAS), 32'd7);
    for (int k = 0; k < 3; k++) step(1'b1, 7'h5E);
    chk("t3_pre_vld", 32'(Valido), 32'd0);
    step(1'b1, 7'h5E);
    chk("t3_notas", 32'(NOTAS), 32'd4);
    chk("t3_cnt", 32'(Contador), 32'd18);

    // T4: one-cycle blank glitch breaks lock on 30
    for (int k = 0; k < 5; k++) step(1'b1, 7'h30);
    chk("t4_lock", 32'(Valido), 32'd1);
    step(1'b1, 7'h00);
    chk("t4_glitch_vld", 32'(Valido), 32'd0);
    chk("t4_glitch_note", 32'({TOM, NOTAS}), 32'h9);
    for (int k = 0; k < 3; k++) step(1'b1, 7'h30);
    chk("t4_relock_pre", 32'(Valido), 32'd0);
    step(1'b1, 7'h30);
    chk("t4_relock", 32'(Valido), 32'd1);
    chk("t4_novo", 32'(Novo), 32'd1);
    chk("t4_cnt", 32'(Contador), 32'd20);

    // T5: unknown pattern 2A, then blank
    novo_seen = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 7'h2A);
    chk("t5_err", 32'(Erro), 32'd1);
    step(1'b1, 7'h2A);
    chk("t5_err_hold", 32'(Erro), 32'd1);
    chk("t5_vld", 32'(Valido), 32'd0);
    chk("t5_no_novo", 32'(novo_seen), 32'd0);
    step(1'b1, 7'h00);
    chk("t5_err_clr", 32'(Erro), 32'd0);

    // T6: 256 acceptances wrap the counter, then reset during settle
    step(1'b0, 7'h00);
    for (int n = 0; n < 256; n++)
      for (int k = 0; k < 4; k++) step(1'b1, (n % 2 == 0) ? 7'h4E : 7'h3D);
    chk("t6_wrap", 32'(Contador), 32'd0);
    chk("t6_vld", 32'(Valido), 32'd1);
    step(1'b1, 7'h77);
    step(1'b1, 7'h77);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 7'h77);
      chk("t6_rst_out", 32'({TOM, NOTAS, Valido, Novo, Erro, Contador}), 32'd0);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 7'h77);
    chk("t6_after_rst_cnt", 32'(Contador), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
